// File: rtl/gfx_mem_pkg.sv
// Shared definitions for the graphics memory family: read-during-write mode
// encoding and the geometry of each graphics resource that maps onto gfx_dpram.
package gfx_mem_pkg;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    typedef struct packed {
        int unsigned depth;
        int unsigned width;
    } mem_geom_t;

    localparam int TILE_BUF_DEPTH = 300;
    localparam int TILE_BUF_W     = 32;
    localparam int TILE_GFX_DEPTH = 2048;
    localparam int TILE_GFX_W     = 32;
    localparam int SPR_GFX_DEPTH  = 2048;
    localparam int SPR_GFX_W      = 32;
    localparam int PALETTE_DEPTH  = 8;
    localparam int PALETTE_W      = 24;
    localparam int PALETTE_BYTE_W = 8;
    localparam int OAM_DEPTH      = 256;
    localparam int OAM_W          = 32;

    localparam mem_geom_t TILE_BUF_GEOM = '{depth: TILE_BUF_DEPTH, width: TILE_BUF_W};
    localparam mem_geom_t TILE_GFX_GEOM = '{depth: TILE_GFX_DEPTH, width: TILE_GFX_W};
    localparam mem_geom_t SPR_GFX_GEOM  = '{depth: SPR_GFX_DEPTH,  width: SPR_GFX_W};
    localparam mem_geom_t PALETTE_GEOM  = '{depth: PALETTE_DEPTH,  width: PALETTE_W};
    localparam mem_geom_t OAM_GEOM      = '{depth: OAM_DEPTH,      width: OAM_W};

endpackage

// File: rtl/gfx_dpram_clear_fsm.sv
// Post-reset clear sequencer: walks every word once writing the clear pattern,
// holding both access ports off (busy) until the last word has been written.
module gfx_dpram_clear_fsm #(
    parameter int DEPTH          = 2048,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    // Sequence state, clear address counter and busy flag; reset always restarts at word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt   <= '0;
            busy  <= CLEAR_ON_RESET;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR) && !reset;
    assign clr_addr = cnt;

endmodule

// File: rtl/gfx_dpram.sv
// True dual-port graphics RAM with byte-lane writes, selectable cross-port
// read-during-write result, same-address write arbitration (port A wins shared
// lanes), out-of-range protection and an optional post-reset clear sweep.
module gfx_dpram #(
    parameter int                 DATA_W         = 32,
    parameter int                 DEPTH          = 2048,
    parameter int                 ADDR_W         = $clog2(DEPTH),
    parameter int                 BYTE_W         = 8,
    parameter int                 RDW_MODE       = 0,
    parameter bit                 CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE     = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       busy,
    output logic                       collision,
    input  logic                       a_en,
    input  logic                       a_we,
    input  logic [DATA_W/BYTE_W-1:0]   a_be,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_wdata,
    output logic [DATA_W-1:0]          a_rdata,
    output logic                       a_rvalid,
    input  logic                       b_en,
    input  logic                       b_we,
    input  logic [DATA_W/BYTE_W-1:0]   b_be,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_wdata,
    output logic [DATA_W-1:0]          b_rdata,
    output logic                       b_rvalid
);

    import gfx_mem_pkg::*;

    localparam int NBE = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam bit  READ_NEW = (RDW_MODE == int'(RDW_NEW));

    if ((DATA_W % BYTE_W) != 0 || DEPTH < 2) begin : g_bad_geometry
        $error("gfx_dpram: DATA_W must be a multiple of BYTE_W and DEPTH must be at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              a_in, b_in;
    logic              a_wr, a_rd, b_wr, b_rd;
    logic              same_addr;
    logic [NBE-1:0]    a_lane, b_lane;
    logic [DATA_W-1:0] a_old, b_old;
    logic [DATA_W-1:0] a_view, b_view;

    gfx_dpram_clear_fsm #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Overlay the enabled lanes of a write onto an existing word
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NBE-1:0]    be
    );
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                r[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return r;
    endfunction

    // Qualify requests (range, busy, reset), arbitrate shared lanes and form the read views
    always_comb begin
        a_in      = ({1'b0, a_addr} < DEPTH_L);
        b_in      = ({1'b0, b_addr} < DEPTH_L);
        a_wr      = !reset && !busy && a_en && a_we && a_in;
        b_wr      = !reset && !busy && b_en && b_we && b_in;
        a_rd      = !reset && !busy && a_en && !a_we;
        b_rd      = !reset && !busy && b_en && !b_we;
        same_addr = (a_addr == b_addr);
        for (int i = 0; i < NBE; i++) begin
            a_lane[i] = a_wr && a_be[i];
            b_lane[i] = b_wr && b_be[i] && !(a_lane[i] && same_addr);
        end
        a_old  = a_in ? mem[a_addr] : '0;
        b_old  = b_in ? mem[b_addr] : '0;
        a_view = a_old;
        b_view = b_old;
        if (READ_NEW) begin
            if (b_wr && same_addr) begin
                a_view = merge_lanes(a_old, b_wdata, b_be);
            end
            if (a_wr && same_addr) begin
                b_view = merge_lanes(b_old, a_wdata, a_be);
            end
        end
    end

    // Storage array: clear sweep while busy, otherwise lane-wise writes from both ports
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < NBE; i++) begin
                if (a_lane[i]) begin
                    mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
                end
                if (b_lane[i]) begin
                    mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered read data, read-valid strobes and the collision pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            a_rvalid  <= a_rd;
            b_rvalid  <= b_rd;
            collision <= a_wr && b_wr && same_addr;
            if (a_rd) begin
                a_rdata <= a_view;
            end
            if (b_rd) begin
                b_rdata <= b_view;
            end
        end
    end

endmodule

// File: tb/tb_gfx_dpram.sv
// Bench for gfx_dpram: two instances (old-data and new-data read-during-write)
// share one stimulus stream and are checked every cycle against a word-level model.
module tb_gfx_dpram;

    localparam int          DEPTH = 300;
    localparam int          AW    = 9;
    localparam int          DW    = 32;
    localparam int          NBE   = 4;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           reset;
    logic           a_en, a_we, b_en, b_we;
    logic [NBE-1:0] a_be, b_be;
    logic [AW-1:0]  a_addr, b_addr;
    logic [DW-1:0]  a_wdata, b_wdata;

    logic           busy0, busy1, coll0, coll1;
    logic [DW-1:0]  a_rdata0, a_rdata1, b_rdata0, b_rdata1;
    logic           a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    logic [31:0] m_mem [DEPTH];
    int          clear_left = 0;
    logic [31:0] m_a_rdata [2];
    logic [31:0] m_b_rdata [2];
    logic        m_a_rvalid, m_b_rvalid, m_coll;
    logic [31:0] old_a, old_b;
    bit          a_ok, b_ok;

    always #5 clk = ~clk;

    gfx_dpram #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BYTE_W(8),
        .RDW_MODE(0), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) dut0 (
        .clk(clk), .reset(reset), .busy(busy0), .collision(coll0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata0), .b_rvalid(b_rvalid0)
    );

    gfx_dpram #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BYTE_W(8),
        .RDW_MODE(1), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) dut1 (
        .clk(clk), .reset(reset), .busy(busy1), .collision(coll1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Word-level reference: clear sweep, then lane writes with port A owning shared lanes
    always @(posedge clk) begin
        if (reset) begin
            clear_left   = DEPTH;
            m_a_rdata[0] = '0; m_a_rdata[1] = '0;
            m_b_rdata[0] = '0; m_b_rdata[1] = '0;
            m_a_rvalid   = 1'b0;
            m_b_rvalid   = 1'b0;
            m_coll       = 1'b0;
        end else if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = INIT;
            clear_left--;
            m_a_rvalid = 1'b0;
            m_b_rvalid = 1'b0;
            m_coll     = 1'b0;
        end else begin
            a_ok  = (int'(a_addr) < DEPTH);
            b_ok  = (int'(b_addr) < DEPTH);
            old_a = a_ok ? m_mem[a_addr] : 32'h0;
            old_b = b_ok ? m_mem[b_addr] : 32'h0;
            m_coll = a_en && a_we && b_en && b_we && a_ok && b_ok && (a_addr == b_addr);
            if (b_en && b_we && b_ok)
                for (int i = 0; i < NBE; i++)
                    if (b_be[i]) m_mem[b_addr][i*8 +: 8] = b_wdata[i*8 +: 8];
            if (a_en && a_we && a_ok)
                for (int i = 0; i < NBE; i++)
                    if (a_be[i]) m_mem[a_addr][i*8 +: 8] = a_wdata[i*8 +: 8];
            m_a_rvalid = a_en && !a_we;
            m_b_rvalid = b_en && !b_we;
            if (m_a_rvalid) begin
                m_a_rdata[0] = old_a;
                m_a_rdata[1] = a_ok ? m_mem[a_addr] : 32'h0;
            end
            if (m_b_rvalid) begin
                m_b_rdata[0] = old_b;
                m_b_rdata[1] = b_ok ? m_mem[b_addr] : 32'h0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy0",     {31'b0, busy0},     {31'b0, clear_left > 0});
            checkOutput("busy1",     {31'b0, busy1},     {31'b0, clear_left > 0});
            checkOutput("coll0",     {31'b0, coll0},     {31'b0, m_coll});
            checkOutput("coll1",     {31'b0, coll1},     {31'b0, m_coll});
            checkOutput("a_rvalid0", {31'b0, a_rvalid0}, {31'b0, m_a_rvalid});
            checkOutput("a_rvalid1", {31'b0, a_rvalid1}, {31'b0, m_a_rvalid});
            checkOutput("b_rvalid0", {31'b0, b_rvalid0}, {31'b0, m_b_rvalid});
            checkOutput("b_rvalid1", {31'b0, b_rvalid1}, {31'b0, m_b_rvalid});
            checkOutput("a_rdata0",  a_rdata0, m_a_rdata[0]);
            checkOutput("a_rdata1",  a_rdata1, m_a_rdata[1]);
            checkOutput("b_rdata0",  b_rdata0, m_b_rdata[0]);
            checkOutput("b_rdata1",  b_rdata1, m_b_rdata[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(
        input bit ae, input bit awe, input logic [3:0] abe, input logic [8:0] aad, input logic [31:0] awd,
        input bit be_, input bit bwe, input logic [3:0] bbe, input logic [8:0] bad, input logic [31:0] bwd
    );
        a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_wdata = awd;
        b_en = be_; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
        tick();
    endtask

    task automatic idleInputs();
        a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic waitClear(input string name, input int expected);
        int count = 0;
        while (busy0 === 1'b1 && count < 2000) begin
            tick();
            count++;
        end
        checkOutput(name, count, expected);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idleInputs();
        tick();
        check_en = 1'b1;
        checkOutput("reset_busy",   {31'b0, busy0},     32'd1);
        checkOutput("reset_rvalid", {31'b0, a_rvalid0}, 32'd0);
        checkOutput("reset_rdata",  a_rdata0,           32'd0);
        checkOutput("reset_coll",   {31'b0, coll0},     32'd0);
        reset = 1'b0;
        waitClear("clear_len", DEPTH);

        // cleared contents at the edges and middle
        applyStimulus(1, 0, 4'h0, 9'd0,   0, 1, 0, 4'h0, 9'd150, 0);
        checkOutput("clr_rd0",   a_rdata0, INIT);
        checkOutput("clr_rd150", b_rdata0, INIT);
        applyStimulus(1, 0, 4'h0, 9'd299, 0, 0, 0, 4'h0, 9'd0,   0);
        checkOutput("clr_rd299", a_rdata0, INIT);

        // byte-lane partial write
        applyStimulus(1, 1, 4'hF, 9'd5, 32'h11223344, 0, 0, 4'h0, 9'd0, 0);
        checkOutput("wr_no_rvalid", {31'b0, a_rvalid0}, 32'd0);
        applyStimulus(1, 1, 4'h2, 9'd5, 32'hAABBCCDD, 0, 0, 4'h0, 9'd0, 0);
        applyStimulus(1, 0, 4'h0, 9'd5, 0,            0, 0, 4'h0, 9'd0, 0);
        checkOutput("be_rd",     a_rdata0,           32'h1122CC44);
        checkOutput("be_rvalid", {31'b0, a_rvalid0}, 32'd1);
        applyStimulus(0, 0, 4'h0, 9'd0, 0, 0, 0, 4'h0, 9'd0, 0);
        checkOutput("be_rvalid_drop", {31'b0, a_rvalid0}, 32'd0);
        checkOutput("be_hold",        a_rdata0,           32'h1122CC44);

        // same-address write collision
        applyStimulus(1, 1, 4'h3, 9'd7, 32'hAAAAAAAA, 1, 1, 4'hE, 9'd7, 32'h55555555);
        checkOutput("coll_pulse", {31'b0, coll0}, 32'd1);
        applyStimulus(1, 0, 4'h0, 9'd7, 0, 0, 0, 4'h0, 9'd0, 0);
        checkOutput("coll_end",  {31'b0, coll0}, 32'd0);
        checkOutput("coll_word", a_rdata0,       32'h5555AAAA);

        // read-during-write on the other port
        applyStimulus(1, 1, 4'hF, 9'd9, 32'h0, 0, 0, 4'h0, 9'd0, 0);
        applyStimulus(1, 1, 4'hF, 9'd9, 32'h12345678, 1, 0, 4'h0, 9'd9, 0);
        checkOutput("rdw_old", b_rdata0, 32'h0);
        checkOutput("rdw_new", b_rdata1, 32'h12345678);

        // out-of-range access
        applyStimulus(1, 1, 4'hF, 9'd300, 32'hFFFFFFFF, 0, 0, 4'h0, 9'd0, 0);
        checkOutput("oob_no_coll", {31'b0, coll0}, 32'd0);
        applyStimulus(1, 0, 4'h0, 9'd300, 0, 1, 0, 4'h0, 9'd44, 0);
        checkOutput("oob_rd",     a_rdata0,           32'h0);
        checkOutput("oob_rvalid", {31'b0, a_rvalid0}, 32'd1);
        checkOutput("oob_44",     b_rdata0,           INIT);

        // randomized traffic, concentrated on a few low words and the range boundary
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] aa, ba;
            aa = ($urandom_range(0, 3) == 0) ? 9'(296 + $urandom_range(0, 7)) : 9'($urandom_range(0, 15));
            ba = ($urandom_range(0, 3) == 0) ? 9'(296 + $urandom_range(0, 7)) : 9'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), aa, $urandom,
                          $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), ba, $urandom);
        end
        idleInputs();
        tick();

        // reset in the middle of a clear sweep, with a request issued while busy
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 120; n++) begin
            if (n == 10) begin
                a_en = 1; a_we = 1; a_be = 4'hF; a_addr = 9'd3; a_wdata = 32'h01020304;
                b_en = 1; b_we = 0; b_addr = 9'd3;
            end else begin
                idleInputs();
            end
            tick();
            if (n == 10) checkOutput("busy_no_rvalid", {31'b0, b_rvalid0}, 32'd0);
        end
        idleInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waitClear("reclear_len", DEPTH);
        applyStimulus(1, 0, 4'h0, 9'd3, 0, 1, 0, 4'h0, 9'd5, 0);
        checkOutput("busy_no_write", a_rdata0, INIT);
        checkOutput("reclear_5",     b_rdata0, INIT);
        idleInputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
